// File: rtl/sample_ram_arbiter_if.sv
// Sample RAM arbiter bus: voice read requests, host write stream, RAM ports.
interface sample_ram_arbiter_if #(
    parameter int ADDR_WIDTH = 19,
    parameter int DATA_WIDTH = 16,
    parameter int N_REQ      = 4,
    parameter int ID_WIDTH   = 2
);
    logic [N_REQ-1:0]            rd_req;
    logic [N_REQ*ADDR_WIDTH-1:0] rd_addr;
    logic [N_REQ-1:0]            rd_gnt;
    logic                        rd_valid;
    logic [ID_WIDTH-1:0]         rd_id;
    logic [DATA_WIDTH-1:0]       rd_data;
    logic                        wr_valid;
    logic                        wr_ready;
    logic [ADDR_WIDTH-1:0]       wr_addr;
    logic [DATA_WIDTH-1:0]       wr_data;
    logic [ADDR_WIDTH-1:0]       ram_addr_a;
    logic [DATA_WIDTH-1:0]       ram_din_a;
    logic                        ram_we_a;
    logic [ADDR_WIDTH-1:0]       ram_addr_b;
    logic [DATA_WIDTH-1:0]       ram_dout_b;

    // Arbiter side
    modport slave (
        input  rd_req, rd_addr, wr_valid, wr_addr, wr_data, ram_dout_b,
        output rd_gnt, rd_valid, rd_id, rd_data, wr_ready,
               ram_addr_a, ram_din_a, ram_we_a, ram_addr_b
    );

    // Requester / host / RAM side
    modport master (
        output rd_req, rd_addr, wr_valid, wr_addr, wr_data, ram_dout_b,
        input  rd_gnt, rd_valid, rd_id, rd_data, wr_ready,
               ram_addr_a, ram_din_a, ram_we_a, ram_addr_b
    );
endinterface

// File: rtl/sample_ram_arbiter.sv
// APU sample RAM controller: round-robin read arbitration over N_REQ voice
// fetch units, registered write port, and a read stall on same-cycle
// write/read address collisions so a granted read always sees newest data.
module sample_ram_arbiter #(
    parameter int ADDR_WIDTH = 19,
    parameter int DATA_WIDTH = 16,
    parameter int N_REQ      = 4,
    parameter int ID_WIDTH   = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
    input  logic                clk,
    input  logic                rst,
    sample_ram_arbiter_if.slave bus
);
    // Grant -> RAM address stage -> RAM data stage -> rd_valid
    localparam int STAGES = 2;

    logic [ID_WIDTH-1:0]               ptr_q, ptr_d;
    logic                              ready_q, ready_d;
    logic [STAGES:0]                   vld_pipe_q, vld_pipe_d;
    logic [STAGES:0][ID_WIDTH-1:0]     id_pipe_q, id_pipe_d;
    logic [DATA_WIDTH-1:0]             rd_data_q, rd_data_d;
    logic [ADDR_WIDTH-1:0]             ram_addr_a_q, ram_addr_a_d;
    logic [DATA_WIDTH-1:0]             ram_din_a_q, ram_din_a_d;
    logic                              ram_we_a_q, ram_we_a_d;
    logic [ADDR_WIDTH-1:0]             ram_addr_b_q, ram_addr_b_d;

    logic                  win_found;
    logic [ID_WIDTH-1:0]   win_idx;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic                  wr_rdy;
    logic                  wr_acc;
    logic                  stall;
    logic                  gnt_any;

    // Round-robin search: first requester strictly after the pointer
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!win_found && bus.rd_req[idx]) begin
                win_found = 1'b1;
                win_idx   = ID_WIDTH'(idx);
            end
        end
    end

    // Collision detect and grant; a stalled winner retries next cycle
    // while writes are blocked, so it cannot be starved.
    always_comb begin
        win_addr   = bus.rd_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        wr_rdy     = ready_q & ~rst;
        wr_acc     = bus.wr_valid & wr_rdy;
        stall      = wr_acc & win_found & (bus.wr_addr == win_addr);
        gnt_any    = win_found & ~stall & ~rst;
        bus.rd_gnt = gnt_any ? ({{(N_REQ-1){1'b0}}, 1'b1} << win_idx) : '0;
    end

    // Next-state for pointer, ready flag, write regs and read pipeline
    always_comb begin
        ptr_d        = gnt_any ? win_idx : ptr_q;
        ready_d      = ~stall;
        ram_we_a_d   = wr_acc;
        ram_addr_a_d = wr_acc ? bus.wr_addr : ram_addr_a_q;
        ram_din_a_d  = wr_acc ? bus.wr_data : ram_din_a_q;
        ram_addr_b_d = gnt_any ? win_addr : ram_addr_b_q;
        vld_pipe_d   = {vld_pipe_q[STAGES-1:0], gnt_any};
        id_pipe_d    = {id_pipe_q[STAGES-1:0], win_idx};
        rd_data_d    = vld_pipe_q[STAGES-1] ? bus.ram_dout_b : rd_data_q;
    end

    // State registers; reset drops in-flight reads and restarts at requester 0
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q        <= ID_WIDTH'(N_REQ - 1);
            ready_q      <= 1'b1;
            vld_pipe_q   <= '0;
            id_pipe_q    <= '0;
            rd_data_q    <= '0;
            ram_addr_a_q <= '0;
            ram_din_a_q  <= '0;
            ram_we_a_q   <= 1'b0;
            ram_addr_b_q <= '0;
        end else begin
            ptr_q        <= ptr_d;
            ready_q      <= ready_d;
            vld_pipe_q   <= vld_pipe_d;
            id_pipe_q    <= id_pipe_d;
            rd_data_q    <= rd_data_d;
            ram_addr_a_q <= ram_addr_a_d;
            ram_din_a_q  <= ram_din_a_d;
            ram_we_a_q   <= ram_we_a_d;
            ram_addr_b_q <= ram_addr_b_d;
        end
    end

    assign bus.wr_ready   = wr_rdy;
    assign bus.rd_valid   = vld_pipe_q[STAGES];
    assign bus.rd_id      = id_pipe_q[STAGES];
    assign bus.rd_data    = rd_data_q;
    assign bus.ram_addr_a = ram_addr_a_q;
    assign bus.ram_din_a  = ram_din_a_q;
    assign bus.ram_we_a   = ram_we_a_q;
    assign bus.ram_addr_b = ram_addr_b_q;
endmodule

// File: tb/tb_sample_ram_arbiter.sv
// Bench for sample_ram_arbiter: vector table for grants / wr_ready,
// scoreboard for returned id, data and read latency.
module tb_sample_ram_arbiter;
    localparam int AW = 19;
    localparam int DW = 16;
    localparam int NR = 4;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sample_ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_REQ(NR), .ID_WIDTH(IW)) bus ();

    sample_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_REQ(NR), .ID_WIDTH(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Cycle counter
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Synchronous RAM model, read-first
    logic [DW-1:0] mem [int];
    initial begin
        bus.ram_dout_b = '0;
        forever begin
            @(posedge clk);
            bus.ram_dout_b <= mem.exists(int'(bus.ram_addr_b)) ? mem[int'(bus.ram_addr_b)] : '0;
            if (bus.ram_we_a) mem[int'(bus.ram_addr_a)] = bus.ram_din_a;
        end
    end

    // Scoreboard: expectation pushed at grant, popped at rd_valid
    typedef struct {
        int            c;
        int            id;
        logic [DW-1:0] d;
    } sb_t;
    sb_t           sb_q[$];
    logic [DW-1:0] shadow [int];

    initial begin
        sb_t e;
        int  gid;
        int  a;
        forever begin
            @(negedge clk);
            if (bus.rd_valid) begin
                chk("rd_valid_expected", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk("rd_id", 32'(bus.rd_id), 32'(e.id));
                    chk("rd_data", 32'(bus.rd_data), 32'(e.d));
                    chk("rd_latency", 32'(cyc), 32'(e.c + 3));
                end
            end
            if (rst) begin
                sb_q.delete();
            end else begin
                if (bus.rd_gnt != '0) begin
                    chk("gnt_onehot", 32'($onehot(bus.rd_gnt)), 32'd1);
                    gid = 0;
                    for (int i = NR - 1; i >= 0; i--) if (bus.rd_gnt[i]) gid = i;
                    a = int'(bus.rd_addr[gid*AW +: AW]);
                    e.c  = cyc;
                    e.id = gid;
                    e.d  = shadow.exists(a) ? shadow[a] : '0;
                    sb_q.push_back(e);
                end
                if (bus.wr_valid && bus.wr_ready) shadow[int'(bus.wr_addr)] = bus.wr_data;
            end
        end
    end

    typedef struct {
        logic [NR-1:0]    req;
        logic [NR*AW-1:0] addr;
        logic             wv;
        logic [AW-1:0]    wa;
        logic [DW-1:0]    wd;
        logic [NR-1:0]    egnt;
        logic             ewr;
        logic             nv;
    } vec_t;

    function automatic vec_t mk(input logic [NR-1:0] req, input int a0, input int a1,
                                input int a2, input int a3, input logic wv, input int wa,
                                input int wd, input logic [NR-1:0] egnt, input logic ewr,
                                input logic nv);
        vec_t v;
        v.req  = req;
        v.addr = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
        v.wv   = wv;
        v.wa   = AW'(wa);
        v.wd   = DW'(wd);
        v.egnt = egnt;
        v.ewr  = ewr;
        v.nv   = nv;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.rd_req   = v.req;
        bus.rd_addr  = v.addr;
        bus.wr_valid = v.wv;
        bus.wr_addr  = v.wa;
        bus.wr_data  = v.wd;
    endtask

    // Apply one cycle, check combinational grant and wr_ready mid-cycle
    task automatic run_vec(input vec_t v, input string nm);
        drive(v);
        @(negedge clk);
        chk({nm, "_gnt"}, 32'(bus.rd_gnt), 32'(v.egnt));
        chk({nm, "_wr_ready"}, 32'(bus.wr_ready), 32'(v.ewr));
        if (v.nv) chk({nm, "_no_rd_valid"}, 32'(bus.rd_valid), 32'd0);
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];

    initial begin
        // Round-robin, req 1111 held for 8 cycles
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(4'b1111, 'h100, 'h101, 'h102, 'h103, 0, 0, 0, 4'(1 << (i % 4)), 1, 0));
        // Preload 0x10..0x13
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 'h10 + i, 'hA000 + i, 4'b0000, 1, 0));
        // Requester 2 back-to-back reads
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(4'b0100, 0, 0, 'h10 + i, 0, 0, 0, 0, 4'b0100, 1, 0));
        // Collision: stall, then grant with writes blocked
        vecs.push_back(mk(4'b0010, 0, 'h55, 0, 0, 1, 'h55, 'h1234, 4'b0000, 1, 0));
        vecs.push_back(mk(4'b0010, 0, 'h55, 0, 0, 0, 0, 0, 4'b0010, 0, 0));
        vecs.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 0));
        // Starvation guard under continuous writes to the same address
        vecs.push_back(mk(4'b0001, 'h55, 0, 0, 0, 1, 'h55, 'h5A5A, 4'b0000, 1, 0));
        vecs.push_back(mk(4'b0001, 'h55, 0, 0, 0, 1, 'h55, 'h5A5B, 4'b0001, 0, 0));
        vecs.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 'h55, 'h5A5C, 4'b0000, 1, 0));
        vecs.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 0));
        // Non-matching write alongside read: no stall
        vecs.push_back(mk(4'b1000, 0, 0, 0, 'h200, 1, 'h201, 'hBEEF, 4'b1000, 1, 0));
        // Write hits a losing requester's address only: no stall
        vecs.push_back(mk(4'b0011, 'h300, 'h301, 0, 0, 1, 'h301, 'hC0DE, 4'b0001, 1, 0));
        vecs.push_back(mk(4'b0010, 0, 'h301, 0, 0, 0, 0, 0, 4'b0010, 1, 0));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        // Reset held 3 cycles with everything requesting
        rst = 1'b1;
        drive(mk(4'b1111, 'h100, 'h101, 'h102, 'h103, 1, 'h7FFFF, 'hFFFF, 4'b0000, 0, 0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_gnt", 32'(bus.rd_gnt), 32'd0);
            chk("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
        end
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_rd_id", 32'(bus.rd_id), 32'd0);
        chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
        chk("rst_ram_we_a", 32'(bus.ram_we_a), 32'd0);
        chk("rst_ram_addr_a", 32'(bus.ram_addr_a), 32'd0);
        chk("rst_ram_din_a", 32'(bus.ram_din_a), 32'd0);
        chk("rst_ram_addr_b", 32'(bus.ram_addr_b), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Mid-operation reset: three reads in flight plus a pending write
        run_vec(mk(4'b1111, 'h300, 'h301, 'h10, 'h11, 0, 0, 0, 4'b0100, 1, 0), "mid_r0");
        run_vec(mk(4'b1111, 'h300, 'h301, 'h10, 'h11, 0, 0, 0, 4'b1000, 1, 0), "mid_r1");
        run_vec(mk(4'b1111, 'h300, 'h301, 'h10, 'h11, 1, 'h20, 'h7777, 4'b0001, 1, 0), "mid_r2");
        rst = 1'b1;
        run_vec(mk(4'b1111, 'h300, 'h301, 'h10, 'h11, 1, 'h20, 'hDEAD, 4'b0000, 0, 0), "mid_rst");
        rst = 1'b0;
        run_vec(mk(4'b0001, 'h20, 0, 0, 0, 0, 0, 0, 4'b0001, 1, 1), "post_rst0");
        v = mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 1);
        run_vec(v, "post_rst1");
        run_vec(v, "post_rst2");
        v.nv = 1'b0;
        for (int i = 0; i < 5; i++) run_vec(v, "drain");

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/sample_ram_arbiter.md
# sample_ram_arbiter

Single-clock controller that sequences the APU sample RAM: one write port and one read port with a registered, one-cycle-latency read. Up to N_REQ voice fetch units share the read port through a round-robin arbiter. Each returned word is tagged with the requester ID. The host/DMA write stream drives the write port. The block resolves the same-cycle write/read address collision by stalling the read, so a granted read always returns the newest data.

## Interface
- ADDR_WIDTH, 19, sample RAM word address width
- DATA_WIDTH, 16, sample word width
- N_REQ, 4, number of read requesters (2..16)
- ID_WIDTH, 2, requester ID width, equal to clog2(N_REQ) (min 1)

- clk  in  1  single clock for the block and the RAM (both RAM clocks tied to it)
- rst  in  1  synchronous, active-high reset
- rd_req  in  N_REQ  per-requester read request; held with its address until granted
- rd_addr  in  N_REQ*ADDR_WIDTH  per-requester address; requester i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH]
- rd_gnt  out  N_REQ  one-hot grant, combinational, at most one bit set
- rd_valid  out  1  return data valid, one-cycle pulse per grant
- rd_id  out  ID_WIDTH  requester index of the returned word
- rd_data  out  DATA_WIDTH  returned word
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted when wr_valid & wr_ready
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- ram_addr_a  out  ADDR_WIDTH  RAM write address (registered)
- ram_din_a  out  DATA_WIDTH  RAM write data (registered)
- ram_we_a  out  1  RAM write enable (registered)
- ram_addr_b  out  ADDR_WIDTH  RAM read address (registered)
- ram_dout_b  in  DATA_WIDTH  RAM read data, valid one cycle after ram_addr_b is presented

## Operation
- **Reset values.** rd_valid, rd_id, rd_data, ram_we_a, ram_addr_a, ram_din_a and ram_addr_b are all 0. The internal pipeline valid bits are 0. The round-robin pointer is N_REQ-1, so requester 0 has priority first. The internal ready flag is 1.
- **Outputs held off during reset.** While rst is high, rd_gnt = 0 and wr_ready = 0. No transaction is accepted in a cycle where rst is high.
- **Round-robin arbitration.**
  - Among the asserted rd_req bits, the winner is the first index after the pointer, searching upward modulo N_REQ.
  - On a grant, the pointer is set to the winner.
  - With no grant, the pointer holds.
  - One grant per cycle at most, so the read port is fully pipelined.
- **Write path.** An accepted write is registered onto ram_addr_a / ram_din_a with ram_we_a = 1 for exactly one cycle. Without an accepted write, ram_we_a = 0 and the address and data registers hold.
- **Collision stall.**
  - Trigger: a write is accepted in cycle T and wr_addr equals the winner's address.
  - Action: rd_gnt = 0 in T and the pointer holds. The same winner is re-evaluated in T+1, where it sees the written data.
  - Reason: without the stall, the RAM would return the old word.
- **Anti-starvation.**
  - The ready flag is registered as "no stall occurred in the previous cycle".
  - wr_ready = ready_flag & ~rst.
  - Effect: after a stall, writes are blocked for one cycle, guaranteeing the stalled read is granted.
- **Read pipeline.**
  - Grant in T → ram_addr_b and the ID are registered at the end of T.
  - The RAM samples during T+1.
  - ram_dout_b is captured into rd_data at the end of T+2.
  - rd_valid = 1 and rd_id = ID in T+3.
- **Reset mid-operation.**
  - In-flight reads are dropped: no rd_valid for them after rst is sampled.
  - A write whose ram_we_a was already high in the rst cycle still completes in the RAM.
  - Arbitration restarts from requester 0.

## Timing
- Read latency: grant cycle T → rd_valid in T+3. Throughput is 1 read per cycle.
- Write latency: accept in T → ram_we_a high in T+1 → memory updated at the end of T+1.
- A read granted in T+1 or later returns the write accepted in T. A read granted in T with a matching address is never issued.
- rd_gnt is combinational from rd_req, rd_addr, wr_valid, wr_addr and the pointer. All other outputs are registered, except wr_ready, which is the ready register gated by rst.
- Non-matching write and read in the same cycle: both proceed with no stall.

## Test plan
- **Reset:** hold rst 3 cycles with all rd_req = 1 and wr_valid = 1 → rd_gnt = 0, wr_ready = 0, all registered outputs 0. After release: gnt = 0001 first, wr_ready = 1.
- **Round-robin:** rd_req = 1111 held for 8 cycles → grant order 0,1,2,3,0,1,2,3. Each rd_valid follows its grant by 3 cycles with the matching rd_id.
- **Pipelined read:** preload RAM[0x10..0x13] = 0xA000..0xA003. Requester 2 reads 0x10..0x13 back-to-back → 4 consecutive rd_valid pulses, data 0xA000..0xA003, rd_id = 2.
- **Collision:** write 0x1234 to address 0x55 in the same cycle requester 1 requests 0x55 (old value 0x0000) → no grant that cycle, grant next cycle, rd_data = 0x1234, wr_ready low for one cycle.
- **Starvation guard:** continuous wr_valid to 0x55 while requester 0 holds a read of 0x55 → grant within 2 cycles. The pattern is stall, then wr_ready = 0, then grant.
- **Mid-operation reset:** 3 reads in flight, rst pulsed for 1 cycle → zero rd_valid pulses after the rst cycle. The next grant goes to requester 0.
